mips_exec_ctrl: RTL and testbench

- Parametrised execution controller for the single-cycle MIPS core. It supersedes the raw step-pulse clock gating.
- Produces a single-clock-domain commit enable `cpu_en` for PC, register file and data memory. The CPU and this block share free-running `clk`.
- Adds debounced buttons, single-step / N-step burst / free-run modes, `NUM_BP` PC breakpoints, halt, and a retired-instruction counter.

---
 rtl/mips_exec_ctrl.sv | 157 +++++++++++++++
 tb/tb_mips_exec_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_ctrl.sv
// Execution controller for the single-cycle MIPS core: debounced step/halt buttons,
// single/burst/run modes, PC breakpoints and a retired-instruction counter.
module mips_exec_ctrl #(
   parameter int PC_WIDTH        = 32,
   parameter int NUM_BP          = 2,
   parameter int BURST_WIDTH     = 8,
   parameter int CNT_WIDTH       = 32,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int BPI_W          = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         step,
   input  logic                         halt,
   input  logic [1:0]                   mode,
   input  logic [BURST_WIDTH-1:0]       burst_count,
   input  logic [NUM_BP*PC_WIDTH-1:0]   bp_addr,
   input  logic [NUM_BP-1:0]            bp_enable,
   input  logic [PC_WIDTH-1:0]          pc,
   input  logic                         clr_count,
   output logic                         cpu_en,
   output logic                         busy,
   output logic                         bp_hit,
   output logic [BPI_W-1:0]             bp_index,
   output logic [CNT_WIDTH-1:0]         instr_count
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] STEP  = 2'd1;
   localparam logic [1:0] BURST = 2'd2;
   localparam logic [1:0] RUN   = 2'd3;

   // Bit 0 is the step button, bit 1 the halt button.
   logic [1:0]      raw, sync1, sync2, filt, filt_d, rise;
   logic [DB_W-1:0] db_cnt [2];

   logic                   step_rise, halt_rise;
   logic [1:0]             state;
   logic [BURST_WIDTH-1:0] burst_cnt;
   logic                   skip_bp;
   logic                   bp_match, stop;
   logic [BPI_W-1:0]       bp_first;

   assign raw = {halt, step};

   // Filter flips only after the synchronised level disagrees for DEBOUNCE_CYCLES cycles in a row.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= '0;
         sync2  <= '0;
         filt   <= '0;
         filt_d <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         filt_d <= filt;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != filt[i]) begin
               if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                  filt[i]   <= sync2[i];
                  db_cnt[i] <= '0;
               end else begin
                  db_cnt[i] <= db_cnt[i] + 1'b1;
               end
            end else begin
               db_cnt[i] <= '0;
            end
         end
      end
   end

   assign rise      = filt & ~filt_d;
   assign step_rise = rise[0];
   assign halt_rise = rise[1];

   // Lowest-index enabled comparator wins.
   always_comb begin
      bp_match = 1'b0;
      bp_first = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_enable[i] && (pc == bp_addr[i*PC_WIDTH +: PC_WIDTH])) begin
            bp_match = 1'b1;
            bp_first = BPI_W'(i);
         end
      end
   end

   assign stop = halt_rise | (bp_match & ~skip_bp);
   assign busy = (state != IDLE);

   always_comb begin
      cpu_en = 1'b0;
      case (state)
         STEP:       cpu_en = 1'b1;
         BURST, RUN: cpu_en = ~stop;
         default:    cpu_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         burst_cnt <= '0;
         skip_bp   <= 1'b0;
         bp_hit    <= 1'b0;
         bp_index  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!halt_rise && step_rise) begin
                  bp_hit <= 1'b0;
                  case (mode)
                     2'b01: begin
                        if (burst_count != '0) begin
                           state     <= BURST;
                           burst_cnt <= burst_count;
                           skip_bp   <= 1'b1;
                        end
                     end
                     2'b10: begin
                        state   <= RUN;
                        skip_bp <= 1'b1;
                     end
                     default: state <= STEP;
                  endcase
               end
            end
            STEP: state <= IDLE;
            BURST, RUN: begin
               skip_bp <= 1'b0;
               if (halt_rise) begin
                  state <= IDLE;
               end else if (stop) begin
                  // The breakpointed instruction stays uncommitted.
                  state    <= IDLE;
                  bp_hit   <= 1'b1;
                  bp_index <= bp_first;
               end else if (state == BURST) begin
                  burst_cnt <= burst_cnt - 1'b1;
                  if (burst_cnt == BURST_WIDTH'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         instr_count <= '0;
      else if (clr_count) instr_count <= '0;
      else if (cpu_en)    instr_count <= instr_count + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: expected commit PCs are queued by the stimulus
// and popped by a monitor on every cpu_en cycle; status outputs are checked per phase.
module tb_mips_exec_ctrl;

   localparam int PC_WIDTH = 32;
   localparam int NUM_BP   = 2;
   localparam int BW       = 8;
   localparam int CW       = 4;
   localparam int DB       = 2;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       step, halt, clr_count;
   logic [1:0]                 mode;
   logic [BW-1:0]              burst_count;
   logic [NUM_BP*PC_WIDTH-1:0] bp_addr;
   logic [NUM_BP-1:0]          bp_enable;
   logic [PC_WIDTH-1:0]        pc;
   logic                       cpu_en, busy, bp_hit;
   logic [0:0]                 bp_index;
   logic [CW-1:0]              instr_count;

   logic [PC_WIDTH-1:0] exp_q [$];
   int                  tests = 0;
   int                  fails = 0;
   int                  commits_seen = 0;
   logic                commit_pend = 1'b0;
   logic [CW-1:0]       model_cnt = '0;

   mips_exec_ctrl #(
      .PC_WIDTH(PC_WIDTH), .NUM_BP(NUM_BP), .BURST_WIDTH(BW),
      .CNT_WIDTH(CW), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk(clk), .reset(reset), .step(step), .halt(halt), .mode(mode),
      .burst_count(burst_count), .bp_addr(bp_addr), .bp_enable(bp_enable),
      .pc(pc), .clr_count(clr_count), .cpu_en(cpu_en), .busy(busy),
      .bp_hit(bp_hit), .bp_index(bp_index), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every committing cycle must match the next queued PC.
   initial forever begin
      @(negedge clk);
      if (reset && cpu_en === 1'b1) begin
         commits_seen++;
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_commit: got pc 0x%0h expected no commit", pc);
         end else begin
            check("commit_pc", 64'(pc), 64'(exp_q.pop_front()));
         end
         commit_pend = 1'b1;
      end
   end

   // Bench plays the CPU: PC advances by 4 after each committed instruction.
   initial forever begin
      @(posedge clk);
      if (commit_pend) begin
         commit_pend = 1'b0;
         #1 pc = pc + 32'd4;
      end
   end

   task automatic expect_commits(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(pc + 32'(4 * i));
      model_cnt = model_cnt + CW'(n);
   endtask

   task automatic press_step(input int hold, input int gap);
      @(posedge clk); #1 step = 1'b1;
      repeat (hold) @(posedge clk);
      #1 step = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1 clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      model_cnt = '0;
   endtask

   initial begin
      int any_busy;
      int target;
      reset = 1'b0; step = 1'b0; halt = 1'b0; clr_count = 1'b0;
      mode = 2'b00; burst_count = '0; bp_addr = '0; bp_enable = '0; pc = '0;

      #1;
      check("rst_cpu_en", 64'(cpu_en), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bp_hit", 64'(bp_hit), 64'd0);
      check("rst_bp_index", 64'(bp_index), 64'd0);
      check("rst_instr_count", 64'(instr_count), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);

      // One-cycle glitch is filtered out.
      press_step(1, 10);
      check("glitch_count", 64'(instr_count), 64'd0);

      // Held step: rise in cycle c+4, single commit in cycle c+5.
      expect_commits(1);
      @(posedge clk); #1 step = 1'b1;
      repeat (5) @(negedge clk);
      check("step_before", 64'(cpu_en), 64'd0);
      @(negedge clk);
      check("step_commit", 64'(cpu_en), 64'd1);
      @(negedge clk);
      check("step_after", 64'(cpu_en), 64'd0);
      repeat (4) @(posedge clk);
      #1 step = 1'b0;
      repeat (8) @(posedge clk);
      check("step_count", 64'(instr_count), 64'd1);

      // Burst of 5.
      pulse_clear();
      mode = 2'b01; burst_count = 8'd5;
      expect_commits(5);
      press_step(3, 12);
      check("burst_q", 64'(exp_q.size()), 64'd0);
      check("burst_busy", 64'(busy), 64'd0);
      check("burst_count", 64'(instr_count), 64'd5);

      // Burst of 0 is a no-op.
      burst_count = 8'd0;
      any_busy = 0;
      @(posedge clk); #1 step = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (busy) any_busy = 1;
         if (i == 2) step = 1'b0;
      end
      check("burst0_busy", 64'(any_busy), 64'd0);
      check("burst0_count", 64'(instr_count), 64'd5);

      // Run into breakpoint 0 at 0x10.
      @(posedge clk); #1 pc = 32'h0;
      mode = 2'b10;
      bp_addr = {32'h20, 32'h10};
      bp_enable = 2'b01;
      expect_commits(4);
      press_step(3, 15);
      check("bp0_q", 64'(exp_q.size()), 64'd0);
      check("bp0_pc", 64'(pc), 64'h10);
      check("bp0_hit", 64'(bp_hit), 64'd1);
      check("bp0_index", 64'(bp_index), 64'd0);
      check("bp0_busy", 64'(busy), 64'd0);

      // Resume from 0x10 executes it first, then stops at breakpoint 1.
      bp_enable = 2'b11;
      expect_commits(4);
      press_step(3, 15);
      check("bp1_q", 64'(exp_q.size()), 64'd0);
      check("bp1_pc", 64'(pc), 64'h20);
      check("bp1_hit", 64'(bp_hit), 64'd1);
      check("bp1_index", 64'(bp_index), 64'd1);

      // Run then halt: step rise c+4, halt raw at c+10 rises at c+14 -> commits c+5..c+13.
      bp_enable = 2'b00;
      expect_commits(9);
      @(posedge clk); #1 step = 1'b1;
      repeat (3) @(posedge clk);
      #1 step = 1'b0;
      repeat (7) @(posedge clk);
      #1 halt = 1'b1;
      repeat (5) @(negedge clk);
      check("halt_drop_en", 64'(cpu_en), 64'd0);
      check("halt_drop_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("halt_idle", 64'(busy), 64'd0);
      @(posedge clk); #1 halt = 1'b0;
      repeat (8) @(posedge clk);
      check("halt_q", 64'(exp_q.size()), 64'd0);
      check("halt_bp_hit", 64'(bp_hit), 64'd0);

      // Step and halt rising together in IDLE: halt wins, nothing executes.
      mode = 2'b00;
      @(posedge clk); #1 step = 1'b1; halt = 1'b1;
      repeat (3) @(posedge clk);
      #1 step = 1'b0; halt = 1'b0;
      repeat (12) @(posedge clk);
      check("both_busy", 64'(busy), 64'd0);
      check("both_count", 64'(instr_count), 64'(model_cnt));

      // 17 single steps wrap the 4-bit counter to 1.
      pulse_clear();
      for (int i = 0; i < 17; i++) begin
         expect_commits(1);
         press_step(3, 8);
      end
      check("wrap_count", 64'(instr_count), 64'd1);

      // clr_count during the commit cycle wins.
      expect_commits(1);
      @(posedge clk); #1 step = 1'b1;
      repeat (3) @(posedge clk);
      #1 step = 1'b0;
      repeat (2) @(posedge clk);
      #1 clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      model_cnt = '0;
      repeat (4) @(posedge clk);
      check("clr_wins", 64'(instr_count), 64'd0);

      // Burst of 200 cut by reset after the 50th commit.
      mode = 2'b01; burst_count = 8'd200;
      exp_q.delete();
      for (int i = 0; i < 50; i++) exp_q.push_back(pc + 32'(4 * i));
      target = commits_seen + 50;
      press_step(3, 0);
      for (int i = 0; i < 400 && commits_seen < target; i++) @(posedge clk);
      check("reset_reached50", 64'(commits_seen >= target), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("rst_mid_cpu_en", 64'(cpu_en), 64'd0);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_count", 64'(instr_count), 64'd0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (20) @(posedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
      check("post_rst_count", 64'(instr_count), 64'd0);
      check("final_q", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
